debounce_filter: RTL
====================

// Module: debounce_filter
// PURPOSE
//  Input-conditioning stage that sits directly upstream of the flip-flop stage. It feeds that stage's d input.
//  - Synchronises a raw asynchronous input (pushbutton/switch) into clk.
//  - Debounces it with a stable-count FSM.
//  - Drives a clean level plus one-cycle rise/fall strobes.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser flop count; legal range >=2
//  CNT_W        16     debounce counter width
//  STABLE_CNT   50000  cycles the synced input must hold before the output follows (1 ms @ 50 MHz); 1 <= STABLE_CNT < 2**CNT_W
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  rst_n       in   1  synchronous, active-low reset
//  din         in   1  raw asynchronous input
//  dout        out  1  debounced level (registered)
//  rise_pulse  out  1  one-cycle strobe when dout goes 0->1
//  fall_pulse  out  1  one-cycle strobe when dout goes 1->0
//  glitch_cnt  out  8  aborted transitions, saturating (present only with DEBOUNCE_GLITCH_CNT_EN)
// BEHAVIOUR
//  Reset
//  - Reset is sampled on posedge clk only.
//  - While rst_n==0: all sync flops=0, state=S_LOW, cnt=0, dout=0, rise_pulse=0, fall_pulse=0, glitch_cnt=0.
//  - A reset asserted mid-count aborts the transition; no pulse is produced.
//  Synchroniser
//  - din passes through a SYNC_STAGES-flop chain; the last flop is din_s.
//  - din_s is the only input the FSM sees.
//  FSM states
//  - S_LOW   dout=0. If din_s==1: go S_RISE, cnt<=0.
//  - S_RISE  dout=0.
//      - din_s==0: go S_LOW (abort).
//      - Else if cnt==STABLE_CNT-1: go S_HIGH, dout<=1, rise_pulse<=1.
//      - Else: cnt<=cnt+1.
//  - S_HIGH  dout=1. If din_s==0: go S_FALL, cnt<=0.
//  - S_FALL  dout=1.
//      - din_s==1: go S_HIGH (abort).
//      - Else if cnt==STABLE_CNT-1: go S_LOW, dout<=0, fall_pulse<=1.
//      - Else: cnt<=cnt+1.
//  Latency
//  - dout changes exactly SYNC_STAGES+STABLE_CNT+1 posedges after the first edge that samples the new din value.
//  - This holds only if din stays stable for that whole window.
//  Strobes
//  - rise_pulse/fall_pulse are registered and high for exactly one cycle.
//  - A strobe is high in the same cycle dout first shows its new value.
//  - The strobes are never high together.
//  - Both strobes default to 0 in every cycle without a transition.
//  Counter
//  - cnt is unsigned, CNT_W bits, and only counts in S_RISE/S_FALL.
//  - It cannot wrap, because the FSM exits at STABLE_CNT-1.
//  - cnt is cleared on every entry to S_RISE/S_FALL.
//  Boundary cases
//  - STABLE_CNT==1: dout follows din_s after 2 edges in the candidate state path (total SYNC_STAGES+2).
//  - A single-cycle glitch in din_s during S_RISE/S_FALL aborts the transition. A new transition then restarts from cnt=0.
//  - din constant high out of reset: dout rises at SYNC_STAGES+STABLE_CNT+1 edges after rst_n deasserts.
// CONFIGURATION
//  DEBOUNCE_GLITCH_CNT_EN defined
//  - Adds output glitch_cnt[7:0].
//  - glitch_cnt increments by 1 on every S_RISE->S_LOW or S_FALL->S_HIGH abort.
//  - It saturates at 255 and is cleared only by reset.
//  DEBOUNCE_GLITCH_CNT_EN undefined
//  - Port and logic are absent.
//  - All other behaviour is identical.
// TESTING (SYNC_STAGES=2, STABLE_CNT=4, CNT_W=4)
//  1. Reset: rst_n=0 for 3 cycles with din=1, then released
//     -> dout=0, pulses=0 during reset.
//     -> dout=1 and rise_pulse=1 on the 7th edge after release.
//  2. Clean rise: din 0->1, held
//     -> dout rises on the 7th edge after the first sample of din=1.
//     -> rise_pulse is high that cycle only; fall_pulse stays 0.
//  3. Bounce: din=1 for 3 cycles, then 0, from S_LOW
//     -> dout stays 0, no pulses.
//     -> glitch_cnt=1 (macro on).
//  4. Clean fall: from dout=1, din 1->0, held
//     -> dout=0 on the 7th edge.
//     -> fall_pulse is high for one cycle only.
//  5. Reset mid-count: rst_n=0 while in S_RISE with cnt=2
//     -> next edge: dout=0, state S_LOW, no rise_pulse.
//     -> after release with din=1, the full 7-edge latency is required again.
//  6. Saturation (macro on): 300 consecutive 2-cycle glitches
//     -> glitch_cnt=255, dout=0 throughout.

Source files
------------

// File: rtl/debounce_filter.sv
// debounce_filter
// Conditions a raw asynchronous input (pushbutton/switch) for synchronous
// logic: a SYNC_STAGES-deep synchroniser followed by a stable-count FSM that
// only lets the output follow once the synced input has held for STABLE_CNT
// cycles. Produces a clean registered level plus one-cycle rise/fall strobes.
//
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add glitch_cnt[7:0], a
// saturating count of aborted transitions (cleared only by reset).
module debounce_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int STABLE_CNT  = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       din,
   output logic       dout,
   output logic       rise_pulse,
   output logic       fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   // Terminal count: the FSM leaves the candidate state here, so cnt never wraps.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   din_s;
   state_t                 state_reg;
   logic [CNT_W-1:0]       cnt_reg;

   // The last synchroniser flop is the only view of din the FSM gets.
   assign din_s = sync_reg[SYNC_STAGES-1];

   // Shift chain bringing din into the clk domain; bit 0 samples the raw pin.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      end
   end

   // Stable-count FSM with registered level, strobes and optional glitch count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= S_LOW;
         cnt_reg    <= '0;
         dout       <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         glitch_cnt <= 8'd0;
`endif
      end else begin
         // Strobes are one-cycle: cleared unless a transition completes below.
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state_reg)
            S_LOW: begin
               if (din_s) begin
                  state_reg <= S_RISE;
                  cnt_reg   <= '0;
               end
            end
            S_RISE: begin
               if (!din_s) begin
                  // Input bounced back before it was stable: abandon the rise.
                  state_reg <= S_LOW;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                  if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
`endif
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg  <= S_HIGH;
                  dout       <= 1'b1;
                  rise_pulse <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_HIGH: begin
               if (!din_s) begin
                  state_reg <= S_FALL;
                  cnt_reg   <= '0;
               end
            end
            S_FALL: begin
               if (din_s) begin
                  // Input bounced back before it was stable: abandon the fall.
                  state_reg <= S_HIGH;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                  if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
`endif
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg  <= S_LOW;
                  dout       <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= S_LOW;
               dout      <= 1'b0;
            end
         endcase
      end
   end

endmodule
